cmul_share_ctrl: RTL and testbench



---
 rtl/cmul_pkg.sv | 11 +
 rtl/cmul_rr_arbiter.sv | 26 ++
 rtl/cmul_share_ctrl.sv | 100 ++++++++++
 tb/tb_cmul_share_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmul_pkg.sv
// cmul_pkg: shared widths, FSM state and tag types for the complex-multiplier share controller
package cmul_pkg;
  localparam int PART_W = 32;
  localparam int CMUL_W = 2 * PART_W;
  localparam int TAG_ID_W = 3;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/cmul_rr_arbiter.sv
// cmul_rr_arbiter: combinational round-robin arbiter with a registered priority pointer
// Ports: clk, rst_n (sync, active-low), req (requests), advance (a grant was taken),
//        grant (one-hot or zero), idx (index of the granted requester)
module cmul_rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx
);
  logic [ID_W-1:0] ptr;
  always_comb begin
    idx = '0;
    // walk from the farthest offset back to ptr so the closest requester wins
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = ID_W'((int'(ptr) + k) % N);
    grant = (|req) ? N'(1) << idx : '0;
  end
  always_ff @(posedge clk)
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= (idx == ID_W'(N - 1)) ? '0 : idx + 1'b1;
endmodule

// File: rtl/cmul_share_ctrl.sv
// cmul_share_ctrl: round-robin sharing of one pipelined complex multiplier with tagged responses and flush/drain
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_a/req_b per-requester operand handshake;
//        rsp_valid (one-hot) / rsp_data result return; mul_a/mul_b/mul_ce/mul_result multiplier side;
//        flush (level) / flush_done (pulse) drain control; idle.
// Optional: define CMUL_SHARE_STATS_EN to add saturating stat_ops and stat_conflict counters.
module cmul_share_ctrl
  import cmul_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 8,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*64-1:0] req_a,
  input  logic [NUM_REQ*64-1:0] req_b,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [63:0]           rsp_data,
  output logic [63:0]           mul_a,
  output logic [63:0]           mul_b,
  output logic                  mul_ce,
  input  logic [63:0]           mul_result,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  idle
`ifdef CMUL_SHARE_STATS_EN
  ,
  output logic [31:0]           stat_ops,
  output logic [31:0]           stat_conflict
`endif
);
  localparam int CNT_W = $clog2(MUL_LATENCY + 2);
  state_t             state, state_nx;
  logic [NUM_REQ-1:0] req_en, grant;
  logic [ID_W-1:0]    idx;
  logic               go;
  logic [CNT_W-1:0]   inflight;
  tag_t               tags [MUL_LATENCY+1];
  tag_t               last;
  // grants only in RUN, never in the cycle flush is seen, never while reset is held
  assign req_en    = req_valid & {NUM_REQ{state == RUN && !flush && rst_n}};
  assign req_ready = grant;
  assign go        = |grant;
  assign mul_ce    = rst_n;
  assign idle      = state == RUN && inflight == '0;
  assign last      = tags[MUL_LATENCY];
  cmul_rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_en),
    .advance (go),
    .grant   (grant),
    .idx     (idx)
  );
  always_comb begin
    state_nx = state;
    state_nx = state == RUN   ? (flush ? DRAIN : RUN) :
               state == DRAIN ? (inflight == '0 ? DONE : DRAIN) :
                                (flush ? DONE : RUN);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      inflight   <= '0;
      tags       <= '{default: '0};
      rsp_valid  <= '0;
      rsp_data   <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nx;
      flush_done <= state == DRAIN && state_nx == DONE;
      tags[0]    <= '{vld: go, id: TAG_ID_W'(idx)};
      for (int i = 1; i <= MUL_LATENCY; i++) tags[i] <= tags[i-1];
      if (go) begin
        mul_a <= req_a[idx*CMUL_W +: CMUL_W];
        mul_b <= req_b[idx*CMUL_W +: CMUL_W];
      end
      inflight  <= inflight + CNT_W'(go) - CNT_W'(last.vld);
      rsp_valid <= last.vld ? NUM_REQ'(1) << last.id : '0;
      if (last.vld) rsp_data <= mul_result;
    end
  end
`ifdef CMUL_SHARE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops      <= '0;
      stat_conflict <= '0;
    end else begin
      if (go && ~&stat_ops) stat_ops <= stat_ops + 1'b1;
      // more than one bit set: clearing the lowest set bit leaves something
      if (state == RUN && (req_valid & (req_valid - 1'b1)) != '0 && ~&stat_conflict)
        stat_conflict <= stat_conflict + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cmul_share_ctrl.sv
// tb_cmul_share_ctrl: directed self-checking bench with an 8-cycle complex-multiplier model
module tb_cmul_share_ctrl;
  localparam int N   = 4;
  localparam int LAT = 8;
  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*64-1:0] req_a, req_b;
  logic [63:0]     rsp_data, mul_a, mul_b, mul_result;
  logic            mul_ce, flush, flush_done, idle;
`ifdef CMUL_SHARE_STATS_EN
  logic [31:0]     stat_ops, stat_conflict;
`endif
  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  logic [63:0] pipe [LAT];
  logic [N-1:0] got_id [$];
  logic [63:0]  got_dat [$];
  int           got_cyc [$];
  int           exp_id [$];
  logic [63:0]  exp_dat [$];
  int           exp_cyc [$];

  cmul_share_ctrl #(.NUM_REQ(N), .MUL_LATENCY(LAT), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_ce     (mul_ce),
    .mul_result (mul_result),
    .flush      (flush),
    .flush_done (flush_done),
    .idle       (idle)
`ifdef CMUL_SHARE_STATS_EN
    ,
    .stat_ops      (stat_ops),
    .stat_conflict (stat_conflict)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] cmul(input logic [63:0] a, input logic [63:0] b);
    logic [31:0] ar, ai, br, bi;
    ar = a[63:32];
    ai = a[31:0];
    br = b[63:32];
    bi = b[31:0];
    return {ar * br - ai * bi, ar * bi + ai * br};
  endfunction

  always @(posedge clk)
    if (mul_ce) begin
      pipe[0] <= cmul(mul_a, mul_b);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  assign mul_result = pipe[LAT-1];

  always @(negedge clk)
    if (rsp_valid != '0) begin
      got_id.push_back(rsp_valid);
      got_dat.push_back(rsp_data);
      got_cyc.push_back(cyc);
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // transfer happens at the edge closing this cycle; the response is visible LAT+1 edges later
  task automatic push_exp(input int id);
    exp_id.push_back(id);
    exp_dat.push_back(cmul(req_a[id*64 +: 64], req_b[id*64 +: 64]));
    exp_cyc.push_back(cyc + 1 + LAT + 1);
  endtask

  task automatic check_rsps(input string tag);
    logic [N-1:0] one;
    check({tag, "_cnt"}, 64'(got_id.size()), 64'(exp_id.size()));
    for (int i = 0; i < exp_id.size() && i < got_id.size(); i++) begin
      one = N'(1) << exp_id[i];
      check({tag, "_id"}, 64'(got_id[i]), 64'(one));
      check({tag, "_dat"}, got_dat[i], exp_dat[i]);
      check({tag, "_cyc"}, 64'(got_cyc[i]), 64'(exp_cyc[i]));
    end
    got_id.delete(); got_dat.delete(); got_cyc.delete();
    exp_id.delete(); exp_dat.delete(); exp_cyc.delete();
  endtask

  initial begin
    int g5, pulses, pc;
    logic [N-1:0] one;
    rst_n = 1'b0;
    flush = 1'b0;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_a[i*64 +: 64] = {32'(i + 1), 32'(i + 2)};
      req_b[i*64 +: 64] = {32'(3), 32'(5 * i + 1)};
    end
    repeat (3) tick;
    #1;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", rsp_data, 64'(0));
    check("rst_mul_a", mul_a, 64'(0));
    check("rst_mul_ce", 64'(mul_ce), 64'(0));
    check("rst_flush_done", 64'(flush_done), 64'(0));
    check("rst_idle", 64'(idle), 64'(1));
    rst_n = 1'b1;
    req_valid = '0;
    tick;
    #1;
    check("run_mul_ce", 64'(mul_ce), 64'(1));
    tick;
    // all four valid for 12 cycles: strict 0,1,2,3 rotation
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      #1;
      one = N'(1) << (k % N);
      check("rr_all_ready", 64'(req_ready), 64'(one));
      push_exp(k % N);
      tick;
    end
    req_valid = '0;
`ifdef CMUL_SHARE_STATS_EN
    check("stat_ops", 64'(stat_ops), 64'(12));
    check("stat_conflict", 64'(stat_conflict), 64'(12));
`endif
    repeat (12) tick;
    check_rsps("rr_all");
    // single op on requester 2
    req_a[2*64 +: 64] = 64'h3F800000_40000000;
    req_b[2*64 +: 64] = 64'h40400000_40800000;
    req_valid = 4'b0100;
    #1;
    check("single_ready", 64'(req_ready), 64'(4'b0100));
    push_exp(2);
    tick;
    req_valid = '0;
    #1;
    check("single_after", 64'(req_ready), 64'(0));
    repeat (12) tick;
    check_rsps("single");
    // pointer sits at 3: 3, then 0 via wrap, then 3 again
    req_valid = 4'b1000;
    #1;
    check("wrap_3", 64'(req_ready), 64'(4'b1000));
    push_exp(3);
    tick;
    req_valid = 4'b1001;
    #1;
    check("wrap_0", 64'(req_ready), 64'(4'b0001));
    push_exp(0);
    tick;
    req_valid = 4'b1000;
    #1;
    check("wrap_3b", 64'(req_ready), 64'(4'b1000));
    push_exp(3);
    tick;
    req_valid = '0;
    repeat (12) tick;
    check_rsps("wrap");
    // five in flight, then drain
    req_valid = '1;
    g5 = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      one = N'(1) << (k % N);
      check("fl_fill", 64'(req_ready), 64'(one));
      push_exp(k % N);
      g5 = cyc;
      tick;
    end
    flush = 1'b1;
    pulses = 0;
    pc = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      check("drain_ready", 64'(req_ready), 64'(0));
      if (flush_done) begin
        pulses++;
        pc = cyc;
      end
      tick;
    end
    #1;
    check("done_pulses", 64'(pulses), 64'(1));
    check("done_cycle", 64'(pc), 64'(g5 + 1 + LAT + 1 + 1));
    check("done_idle", 64'(idle), 64'(0));
    flush = 1'b0;
    #1;
    check("done_ready", 64'(req_ready), 64'(0));
    tick;
    #1;
    check("resume_ready", 64'(req_ready), 64'(4'b0010));
    push_exp(1);
    tick;
    req_valid = '0;
    repeat (12) tick;
    check_rsps("flush");
    #1;
    check("flush_idle", 64'(idle), 64'(1));
    tick;
    // six in flight, then a one-cycle reset discards them
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      #1;
      one = N'(1) << ((k + 2) % N);
      check("rst_fill", 64'(req_ready), 64'(one));
      tick;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'(0));
    check("mid_rst_ce", 64'(mul_ce), 64'(0));
    tick;
    check("mid_rst_idle", 64'(idle), 64'(1));
    check("mid_rst_rsp", 64'(rsp_valid), 64'(0));
    rst_n = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      tick;
      check("rst_quiet", 64'(rsp_valid), 64'(0));
    end
    check("rst_rsp_cnt", 64'(got_id.size()), 64'(0));
    req_valid = '1;
    #1;
    check("rst_ptr", 64'(req_ready), 64'(4'b0001));
    req_valid = '0;
    tick;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
